// File: rtl/stream_mux_n_pkg.sv
// Shared definitions for the N-way stream multiplexer.
// State encoding and an elaboration-time log2 helper.
package stream_mux_n_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_mux_n_rr_pick.sv
// Rotating priority finder: first set request after ptr_i,
// wrapping modulo N.
module stream_mux_n_rr_pick
    import stream_mux_n_pkg::*;
#(
    parameter int N    = 6,
    parameter int SELW = 3
) (
    input  logic [N-1:0]    req_i,
    input  logic [SELW-1:0] ptr_i,
    output logic            found_o,
    output logic [SELW-1:0] idx_o
);

    // Walk backwards so the nearest channel after ptr_i wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int k = N; k >= 1; k--) begin
            if (req_i[(int'(ptr_i) + k) % N]) begin
                found_o = 1'b1;
                idx_o   = SELW'((int'(ptr_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// N-way valid/ready stream multiplexer with packet locking,
// fixed or round-robin selection and a registered output.
module stream_mux_n
    import stream_mux_n_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NUM_INPUTS = 6,
    parameter int SELW       = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mode,
    input  logic [SELW-1:0]             sel,
    input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]       in_valid,
    input  logic [NUM_INPUTS-1:0]       in_last,
    output logic [NUM_INPUTS-1:0]       in_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_valid,
    output logic                        out_last,
    input  logic                        out_ready,
    output logic [SELW-1:0]             grant
);

    if (clog2(NUM_INPUTS) > SELW || NUM_INPUTS < 2) begin : g_bad_params
        $error("stream_mux_n: SELW too small or NUM_INPUTS < 2");
    end

    state_e            state_q, state_d;
    logic [SELW-1:0]   lock_q, lock_d;
    logic [SELW-1:0]   rr_q, rr_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [SELW-1:0]   grant_q, grant_d;

    logic              load_en;
    logic              rr_found;
    logic [SELW-1:0]   rr_idx;
    logic [SELW-1:0]   sel_fix;
    logic [SELW-1:0]   ch;
    logic              cand;
    logic              xfer;

    stream_mux_n_rr_pick #(
        .N    (NUM_INPUTS),
        .SELW (SELW)
    ) u_rr_pick (
        .req_i   (in_valid),
        .ptr_i   (rr_q),
        .found_o (rr_found),
        .idx_o   (rr_idx)
    );

    assign load_en = !valid_q || out_ready;
    assign sel_fix = (int'(sel) >= NUM_INPUTS)
                   ? SELW'(NUM_INPUTS - 1) : sel;

    always_comb begin
        ch   = '0;
        cand = 1'b0;
        if (state_q == ST_LOCKED) begin
            ch   = lock_q;
            cand = in_valid[lock_q];
        end else if (mode) begin
            ch   = rr_idx;
            cand = rr_found;
        end else begin
            ch   = sel_fix;
            cand = 1'b1;
        end
    end

    assign in_ready = (load_en && cand)
                    ? (NUM_INPUTS'(1) << ch) : '0;
    assign xfer     = load_en && cand && in_valid[ch];

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        rr_d    = rr_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        grant_d = grant_q;
        if (load_en) begin
            valid_d = xfer;
            if (xfer) begin
                data_d  = in_data[int'(ch)*WIDTH +: WIDTH];
                last_d  = in_last[ch];
                grant_d = ch;
            end
        end
        // A last beat always frees the output and advances fairness.
        if (xfer) begin
            if (in_last[ch]) begin
                state_d = ST_IDLE;
                rr_d    = ch;
            end else if (state_q == ST_IDLE) begin
                state_d = ST_LOCKED;
                lock_d  = ch;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lock_q  <= '0;
            rr_q    <= SELW'(NUM_INPUTS - 1);
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            rr_q    <= rr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign grant     = grant_q;

endmodule
